// File: rtl/instruction_fetcher_pkg.sv
// rtl/instruction_fetcher_pkg.sv - shared Isa package: instruction word layout and op-codes
package Isa;

  typedef enum logic [7:0] {
    NOP   = 8'h00,
    ADD   = 8'h01,
    MUL   = 8'h02,
    AND   = 8'h03,
    OR    = 8'h04,
    XOR   = 8'h05,
    LOAD  = 8'h06,
    STORE = 8'h07
  } Opcode;

  typedef struct packed {
    Opcode      op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
  } Instruction;

endpackage

// File: rtl/instruction_fetcher_fifo.sv
// rtl/instruction_fetcher_fifo.sv - synchronous prefetch FIFO; head is zero while empty
module instruction_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge i_clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetcher.sv
// rtl/instruction_fetcher.sv - streams a program from single-port RAM to the processor
module instruction_fetcher
  import Isa::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic [ADDR_WIDTH-1:0]         i_base_addr,
  input  logic [ADDR_WIDTH:0]           i_length,
  output logic                          o_ram_read_en,
  output logic [ADDR_WIDTH-1:0]         o_ram_addr,
  input  logic [$bits(Instruction)-1:0] i_ram_rdata,
  output logic [$bits(Instruction)-1:0] o_instruction,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int IW = $bits(Instruction);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH:0]   length;
  logic [ADDR_WIDTH:0]   issued;
  logic [ADDR_WIDTH:0]   accepted;
  logic                  inflight;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  strobe;
  logic                  pop;
  logic [CW:0]           credit_used;

  // a read in flight already owns a FIFO slot, so it counts against the credit
  assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign strobe      = (state == FETCH) && (issued != length) && !fifo_full
                       && (credit_used < CREDIT_LIMIT);
  assign pop         = !fifo_empty && i_ready;

  assign o_ram_read_en = strobe;
  assign o_ram_addr    = strobe ? base + issued[ADDR_WIDTH-1:0] : '0;
  assign o_valid       = !fifo_empty;
  assign o_busy        = (state != IDLE);
  assign o_done        = (state == DONE);

  instruction_fifo #(
    .WIDTH (IW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .push      (inflight),
    .push_data (i_ram_rdata),
    .pop       (pop),
    .pop_data  (o_instruction),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      base     <= '0;
      length   <= '0;
      issued   <= '0;
      accepted <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= strobe;
      if (strobe) issued   <= issued + 1'b1;
      if (pop)    accepted <= accepted + 1'b1;
      case (state)
        IDLE: begin
          if (i_start) begin
            base     <= i_base_addr;
            length   <= i_length;
            issued   <= '0;
            accepted <= '0;
            state    <= (i_length == '0) ? DONE : FETCH;
          end
        end
        FETCH: if (strobe && (issued + 1'b1 == length)) state <= DRAIN;
        DRAIN: if (pop && (accepted + 1'b1 == length)) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetcher.sv
// tb/tb_instruction_fetcher.sv - self-checking bench for instruction_fetcher
module tb_instruction_fetcher;
  import Isa::*;

  localparam int AW    = 10;
  localparam int WORDS = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          i_start;
  logic [AW-1:0] i_base_addr;
  logic [AW:0]   i_length;
  logic          o_ram_read_en;
  logic [AW-1:0] o_ram_addr;
  logic [31:0]   i_ram_rdata;
  logic [31:0]   o_instruction;
  logic          o_valid;
  logic          i_ready;
  logic          o_busy;
  logic          o_done;

  int checks;
  int failures;

  logic [31:0] ram [WORDS];
  logic [31:0] got[$];
  int          addr_log[$];

  instruction_fetcher #(.ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_start       (i_start),
    .i_base_addr   (i_base_addr),
    .i_length      (i_length),
    .o_ram_read_en (o_ram_read_en),
    .o_ram_addr    (o_ram_addr),
    .i_ram_rdata   (i_ram_rdata),
    .o_instruction (o_instruction),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with one-cycle read latency, plus logs of strobed addresses and transfers
  always @(posedge clk) begin
    if (o_ram_read_en) begin
      i_ram_rdata <= ram[o_ram_addr];
      addr_log.push_back(int'(o_ram_addr));
    end
    if (o_valid && i_ready) got.push_back(o_instruction);
  end

  function automatic logic [31:0] mk(input Opcode op, input logic [7:0] a, b, c);
    return {op, a, b, c};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_prog(input int b, input int len);
    got.delete();
    addr_log.delete();
    @(negedge clk);
    i_start     = 1'b1;
    i_base_addr = AW'(b);
    i_length    = (AW+1)'(len);
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // run until o_done, driving i_ready at pct percent; optional start poke while busy
  task automatic finish_prog(input int pct, input bit poke);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (o_done) begin
        seen = 1'b1;
        check("done_busy", o_busy, 1);
        check("done_valid", o_valid, 0);
      end else begin
        @(negedge clk);
        i_ready = ($urandom_range(0, 99) < pct);
        if (poke && i == 4) begin
          i_start     = 1'b1;
          i_base_addr = AW'(100);
          i_length    = (AW+1)'(5);
        end else begin
          i_start = 1'b0;
        end
      end
    end
    i_start = 1'b0;
    check("done_seen", seen, 1);
    @(negedge clk);
    check("done_pulse_once", o_done, 0);
    check("busy_after_done", o_busy, 0);
  endtask

  // reference: the program is simply ram[(base+k) mod 2^AW] for k in [0,len)
  task automatic compare(input string tag, input int b, input int len);
    check({tag, "_nwords"}, got.size(), len);
    check({tag, "_nreads"}, addr_log.size(), len);
    for (int k = 0; k < len && k < got.size(); k++)
      check({tag, "_word"}, got[k], ram[(b + k) % WORDS]);
    for (int k = 0; k < len && k < addr_log.size(); k++)
      check({tag, "_addr"}, addr_log[k], (b + k) % WORDS);
  endtask

  initial begin
    int b;
    checks   = 0;
    failures = 0;
    rst_n       = 1'b0;
    i_start     = 1'b0;
    i_base_addr = '0;
    i_length    = '0;
    i_ready     = 1'b0;
    i_ram_rdata = '0;
    for (int k = 0; k < WORDS; k++) ram[k] = $urandom;
    ram[5] = mk(ADD, 8'd1, 8'd2, 8'd3);
    ram[6] = mk(MUL, 8'd4, 8'd5, 8'd6);
    ram[7] = mk(AND, 8'd7, 8'd8, 8'd9);

    // reset state
    #12;
    check("rst_valid", o_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_rd_en", o_ram_read_en, 0);
    check("rst_addr", o_ram_addr, 0);
    check("rst_instr", o_instruction, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic three-word program, cycle-exact timing
    i_ready = 1'b1;
    start_prog(5, 3);
    check("c1_rd_en", o_ram_read_en, 1);
    check("c1_addr", o_ram_addr, 5);
    check("c1_busy", o_busy, 1);
    check("c1_valid", o_valid, 0);
    @(negedge clk);
    check("c2_addr", o_ram_addr, 6);
    check("c2_valid", o_valid, 0);
    @(negedge clk);
    check("c3_valid", o_valid, 1);
    check("c3_instr", o_instruction, mk(ADD, 8'd1, 8'd2, 8'd3));
    @(negedge clk);
    check("c4_instr", o_instruction, mk(MUL, 8'd4, 8'd5, 8'd6));
    check("c4_rd_en", o_ram_read_en, 0);
    @(negedge clk);
    check("c5_instr", o_instruction, mk(AND, 8'd7, 8'd8, 8'd9));
    @(negedge clk);
    check("c6_done", o_done, 1);
    check("c6_busy", o_busy, 1);
    check("c6_valid", o_valid, 0);
    @(negedge clk);
    check("c7_done", o_done, 0);
    check("c7_busy", o_busy, 0);
    compare("basic", 5, 3);

    // back-pressure: ready low for 10 cycles stalls reads at FIFO depth
    i_ready = 1'b0;
    start_prog(5, 8);
    for (int c = 1; c <= 10; c++) begin
      if (c >= 3) check("bp_stable", o_instruction, ram[5]);
      @(negedge clk);
    end
    check("bp_strobes", addr_log.size(), 4);
    i_ready = 1'b1;
    finish_prog(100, 1'b0);
    compare("bp", 5, 8);

    // reset mid-FETCH: two words buffered, one read in flight
    i_ready = 1'b0;
    start_prog(5, 8);
    repeat (3) @(negedge clk);
    check("mr_pre_reads", addr_log.size(), 3);
    check("mr_pre_rd_en", o_ram_read_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_valid", o_valid, 0);
    check("mr_rd_en", o_ram_read_en, 0);
    check("mr_addr", o_ram_addr, 0);
    check("mr_instr", o_instruction, 0);
    check("mr_busy", o_busy, 0);
    check("mr_done", o_done, 0);
    @(negedge clk);
    rst_n   = 1'b1;
    i_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("mr_post_valid", o_valid, 0);
    check("mr_post_busy", o_busy, 0);
    check("mr_post_words", got.size(), 0);

    // address wrap at the top of RAM
    start_prog(WORDS - 2, 4);
    finish_prog(100, 1'b0);
    compare("wrap", WORDS - 2, 4);

    // zero-length program
    start_prog(9, 0);
    check("z_done", o_done, 1);
    check("z_rd_en", o_ram_read_en, 0);
    check("z_valid", o_valid, 0);
    @(negedge clk);
    check("z_done_end", o_done, 0);
    check("z_busy", o_busy, 0);
    check("z_reads", addr_log.size(), 0);

    // 28-word program with zero words, random ready, start poked while busy
    b = $urandom_range(0, WORDS - 1);
    for (int k = 0; k < 28; k++) ram[(b + k) % WORDS] = (k % 5 == 2) ? 32'h0 : $urandom;
    i_ready = 1'b0;
    start_prog(b, 28);
    finish_prog(60, 1'b1);
    compare("rand", b, 28);
    repeat (3) @(negedge clk);
    check("rand_no_restart", o_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
